// File: rtl/pe_window_feeder_if.sv
// Pixel-stream and window bundle between a pixel source, the window feeder and the 3x3 PE.
// Pure wiring; it adds no latency.
// The pixel side is valid/ready; the window side has no ready because the PE never stalls.
interface pe_window_feeder_if;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [71:0] win_out;
  logic        win_en;
  logic        win_last;

  // Pixel source / window consumer side
  modport master (
    output pix_in,
    output pix_valid,
    input  pix_ready,
    input  win_out,
    input  win_en,
    input  win_last
  );

  // Feeder side
  modport slave (
    input  pix_in,
    input  pix_valid,
    output pix_ready,
    output win_out,
    output win_en,
    output win_last
  );
endinterface

// File: rtl/pe_window_feeder.sv
// Turns a raster pixel stream into 3x3 windows for the PE using two line buffers.
// Latency: a window appears one cycle after the pixel that completes it is accepted.
// Backpressure: ready only while a frame runs; window output is fire-and-forget.
// Optional feature macro WIN_FEEDER_STRIDE2_EN adds cfg_stride2 (emit every other row/column).
module pe_window_feeder #(
  parameter int MAX_W    = 64,
  parameter int DIM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DIM_BITS-1:0] cfg_width,
  input  logic [DIM_BITS-1:0] cfg_height,
`ifdef WIN_FEEDER_STRIDE2_EN
  input  logic                cfg_stride2,
`endif
  pe_window_feeder_if.slave   strm,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [DIM_BITS-1:0] ONE   = DIM_BITS'(1);
  localparam logic [DIM_BITS-1:0] TWO   = DIM_BITS'(2);
  localparam logic [DIM_BITS-1:0] THREE = DIM_BITS'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DIM_BITS-1:0] w_lat, h_lat;
  logic [DIM_BITS-1:0] r, c;
  logic [AW-1:0]       c_idx;

  // Line buffers: lb0 holds the previous row, lb1 the row before that.
  logic [7:0] lb0 [MAX_W];
  logic [7:0] lb1 [MAX_W];
  logic [7:0] lb0_rd, lb1_rd;

  // Window register; byte k = 3*row + col.
  logic [8:0][7:0] win_q;
  logic            win_en_q, win_last_q;

  logic cfg_ok, start_ok, start_bad;
  logic xfer, pix_ready_c, busy_c;
  logic last_col, last_pix;
  logic stride_on, emit_ok, at_last_win;
  logic [DIM_BITS-1:0] hm1, wm1, last_r, last_c;

  // A start is legal when 3 <= W <= MAX_W and H >= 3.
  assign cfg_ok = (cfg_width >= THREE) &&
                  (32'(cfg_width) <= 32'(MAX_W)) &&
                  (cfg_height >= THREE);

  // A pixel moves only while running; a reset cycle never counts as a transfer.
  assign xfer = strm.pix_valid && (state == S_RUN) && reset;

  assign c_idx    = c[AW-1:0];
  assign last_col = (c == w_lat - ONE);
  assign last_pix = last_col && (r == h_lat - ONE);

  // Read ports see the contents from before this cycle's write.
  assign lb0_rd = lb0[c_idx];
  assign lb1_rd = lb1[c_idx];

`ifdef WIN_FEEDER_STRIDE2_EN
  logic stride_q;

  // Stride selection is captured with the rest of the frame configuration.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stride_q <= 1'b0;
    end else if (start_ok) begin
      stride_q <= cfg_stride2;
    end
  end

  assign stride_on = stride_q;
`else
  assign stride_on = 1'b0;
`endif

  // With stride 2 the last emitted row/column is the largest even index that fits.
  assign hm1    = h_lat - ONE;
  assign wm1    = w_lat - ONE;
  assign last_r = stride_on ? {hm1[DIM_BITS-1:1], 1'b0} : hm1;
  assign last_c = stride_on ? {wm1[DIM_BITS-1:1], 1'b0} : wm1;

  // Columns 0/1 of a row hold stale data from the previous row, so they never emit.
  assign emit_ok     = (r >= TWO) && (c >= TWO) &&
                       (!stride_on || (!r[0] && !c[0]));
  assign at_last_win = (r == last_r) && (c == last_c);

  // Frame-control state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the handshake/status outputs of each state.
  always_comb begin
    state_nxt   = state;
    pix_ready_c = 1'b0;
    busy_c      = 1'b0;
    start_ok    = 1'b0;
    start_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            start_ok  = 1'b1;
            state_nxt = S_RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_RUN: begin
        pix_ready_c = 1'b1;
        busy_c      = 1'b1;
        if (xfer && last_pix) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign strm.pix_ready = pix_ready_c;
  assign busy           = busy_c;

  // Frame geometry is frozen at start; later cfg changes have no effect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_lat <= '0;
      h_lat <= '0;
    end else if (start_ok) begin
      w_lat <= cfg_width;
      h_lat <= cfg_height;
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r <= '0;
      c <= '0;
    end else if (start_ok) begin
      r <= '0;
      c <= '0;
    end else if (xfer) begin
      if (last_col) begin
        c <= '0;
        r <= r + ONE;
      end else begin
        c <= c + ONE;
      end
    end
  end

  // Line buffers roll down one row per accepted pixel; contents are not reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb1[c_idx] <= lb0_rd;
      lb0[c_idx] <= strm.pix_in;
    end
  end

  // Window shifts left one column per accepted pixel; the new column enters at col 2.
  always_ff @(posedge clk) begin
    if (!reset) begin
      win_q <= '0;
    end else if (xfer) begin
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= lb1_rd;
      win_q[3] <= win_q[4];
      win_q[4] <= win_q[5];
      win_q[5] <= lb0_rd;
      win_q[6] <= win_q[7];
      win_q[7] <= win_q[8];
      win_q[8] <= strm.pix_in;
    end
  end

  // Enable/last strobes fire only in the cycle after a qualifying transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      win_en_q   <= 1'b0;
      win_last_q <= 1'b0;
    end else begin
      win_en_q   <= xfer && emit_ok;
      win_last_q <= xfer && emit_ok && at_last_win;
    end
  end

  assign strm.win_out  = win_q;
  assign strm.win_en   = win_en_q;
  assign strm.win_last = win_last_q;

  // done follows the DONE state by a cycle so the last window leads it; cfg_err flags a rejected start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= (state == S_DONE);
      cfg_err <= start_bad;
    end
  end

  // win_last can only accompany a window.
  assert property (@(posedge clk) disable iff (!reset) strm.win_last |-> strm.win_en);

  // done and the final window never share a cycle.
  assert property (@(posedge clk) disable iff (!reset) done |-> !strm.win_en);

endmodule

// File: tb/tb_pe_window_feeder.sv
// Scoreboard bench for pe_window_feeder: the driver predicts each window from the pixel formula.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_pe_window_feeder;
  localparam int MAX_W    = 64;
  localparam int DIM_BITS = 8;

  logic                clk;
  logic                reset;
  logic                start;
  logic [DIM_BITS-1:0] cfg_width;
  logic [DIM_BITS-1:0] cfg_height;
  logic                busy, done, cfg_err;
`ifdef WIN_FEEDER_STRIDE2_EN
  logic                cfg_stride2;
`endif

  pe_window_feeder_if bus ();

  pe_window_feeder #(.MAX_W(MAX_W), .DIM_BITS(DIM_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
`ifdef WIN_FEEDER_STRIDE2_EN
    .cfg_stride2(cfg_stride2),
`endif
    .strm       (bus),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] win;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_win = 0;
  logic xfer_prev = 1'b0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int r, input int c, input int w, input int base);
    return 8'((r * w + c + base) & 255);
  endfunction

  // Every window must match the prediction and follow a transfer by exactly one cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.win_en) begin
      n_win++;
      check("en_after_xfer", 80'(xfer_prev), 80'(1));
      if (exp_q.size() == 0) begin
        check("unexpected_win", 80'(1), 80'(0));
      end else begin
        e = exp_q.pop_front();
        check("win_out", 80'(bus.win_out), 80'(e.win));
        check("win_last", 80'(bus.win_last), 80'(e.last));
      end
    end
    xfer_prev = bus.pix_valid && bus.pix_ready;
  end

  task automatic run_frame(input int w, input int h, input bit gaps, input bit s2,
                           input int base, input int abort_at);
    int   lastr, lastc, n_xfer, win0, exp_wins, bound;
    bit   ok, on_final;
    exp_t e;
    lastr = h - 1;
    lastc = w - 1;
    if (s2 && (lastr % 2 == 1)) lastr--;
    if (s2 && (lastc % 2 == 1)) lastc--;
    on_final = (lastr == h - 1) && (lastc == w - 1);
    exp_wins = s2 ? ((w - 1) / 2) * ((h - 1) / 2) : (w - 2) * (h - 2);
    win0   = n_win;
    n_xfer = 0;

    start      = 1'b1;
    cfg_width  = DIM_BITS'(w);
    cfg_height = DIM_BITS'(h);
`ifdef WIN_FEEDER_STRIDE2_EN
    cfg_stride2 = s2;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_run", 80'(busy), 80'(1));

    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (abort_at >= 0 && n_xfer == abort_at) begin
          reset         = 1'b0;
          bus.pix_valid = 1'b0;
          @(posedge clk); #1;
          check("abort_busy", 80'(busy), 80'(0));
          check("abort_ready", 80'(bus.pix_ready), 80'(0));
          check("abort_en", 80'(bus.win_en), 80'(0));
          reset = 1'b1;
          for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 80'(done), 80'(0));
          end
          check("abort_q_empty", 80'(exp_q.size()), 80'(0));
          exp_q.delete();
          return;
        end
        bus.pix_in    = pix_val(r, c, w, base);
        bus.pix_valid = 1'b1;
        if (r >= 2 && c >= 2 && (!s2 || (r % 2 == 0 && c % 2 == 0))) begin
          for (int k = 0; k < 9; k++)
            e.win[8*k +: 8] = pix_val(r - 2 + k / 3, c - 2 + k % 3, w, base);
          e.last = (r == lastr) && (c == lastc);
          exp_q.push_back(e);
        end
        ok    = 1'b0;
        bound = 0;
        while (!ok) begin
          ok = bus.pix_ready;
          @(posedge clk); #1;
          if (!ok) begin
            bound++;
            if (bound > 100) begin
              check("ready_timeout", 80'(0), 80'(1));
              bus.pix_valid = 1'b0;
              return;
            end
          end
        end
        n_xfer++;
        if (gaps && !(r == h - 1 && c == w - 1)) begin
          bus.pix_valid = 1'b0;
          bus.pix_in    = 8'hA5;
          @(posedge clk); #1;
        end
      end
    end

    bus.pix_valid = 1'b0;
    check("last_en", 80'({bus.win_en, bus.win_last}), on_final ? 80'(3) : 80'(0));
    check("done_early", 80'(done), 80'(0));
    check("ready_in_done", 80'(bus.pix_ready), 80'(0));
    @(posedge clk); #1;
    check("done_pulse", 80'(done), 80'(1));
    check("busy_after", 80'(busy), 80'(0));
    @(posedge clk); #1;
    check("done_once", 80'(done), 80'(0));
    check("win_count", 80'(n_win - win0), 80'(exp_wins));
    check("q_empty", 80'(exp_q.size()), 80'(0));
  endtask

  task automatic bad_cfg(input int w, input int h);
    bus.pix_valid = 1'b1;
    start         = 1'b1;
    cfg_width     = DIM_BITS'(w);
    cfg_height    = DIM_BITS'(h);
    @(posedge clk); #1;
    start = 1'b0;
    check("cfg_err_pulse", 80'(cfg_err), 80'(1));
    check("cfg_err_busy", 80'(busy), 80'(0));
    check("cfg_err_ready", 80'(bus.pix_ready), 80'(0));
    @(posedge clk); #1;
    check("cfg_err_once", 80'(cfg_err), 80'(0));
    check("cfg_err_idle", 80'(busy), 80'(0));
    bus.pix_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    cfg_width     = '0;
    cfg_height    = '0;
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
`ifdef WIN_FEEDER_STRIDE2_EN
    cfg_stride2   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_win_out", 80'(bus.win_out), 80'(0));
    check("rst_win_en", 80'(bus.win_en), 80'(0));
    check("rst_win_last", 80'(bus.win_last), 80'(0));
    check("rst_ready", 80'(bus.pix_ready), 80'(0));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_done", 80'(done), 80'(0));
    check("rst_cfg_err", 80'(cfg_err), 80'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    run_frame(5, 4, 1'b0, 1'b0, 1, -1);      // basic frame, streaming
    run_frame(5, 4, 1'b1, 1'b0, 1, -1);      // same frame with valid gaps
    bad_cfg(2, 4);                           // width too small
    bad_cfg(MAX_W + 1, 4);                   // width too large
    bad_cfg(5, 2);                           // height too small
    run_frame(5, 4, 1'b0, 1'b0, 1, 9);       // reset mid-frame
    run_frame(5, 4, 1'b0, 1'b0, 1, -1);      // restart after abort
    run_frame(MAX_W, 3, 1'b0, 1'b0, 0, -1);  // full-width line buffers
    run_frame(3, 3, 1'b1, 1'b0, 7, -1);      // minimum frame, single window
`ifdef WIN_FEEDER_STRIDE2_EN
    run_frame(7, 7, 1'b0, 1'b1, 1, -1);      // stride 2, last window at frame end
    run_frame(8, 6, 1'b0, 1'b1, 3, -1);      // stride 2, last window before frame end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
